// File: rtl/xorshift_pkg.sv
// Shared constants, FSM state type and xorshift step for xorshift_multi.
// xs_step works on a 64-bit container masked to the lane width.
package xorshift_pkg;

  localparam logic [31:0] GOLDEN32 = 32'h9E37_79B9;
  localparam logic [63:0] GOLDEN64 = 64'h9E37_79B9_7F4A_7C15;

  localparam int SH32_A = 13;
  localparam int SH32_B = 17;
  localparam int SH32_C = 5;
  localparam int SH64_A = 13;
  localparam int SH64_B = 7;
  localparam int SH64_C = 17;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_WARMUP,
    ST_RUN
  } state_t;

  // Left shifts are masked right away so bits pushed past the
  // lane width never come back down through the right shift.
  function automatic logic [63:0] xs_step(
    input logic [63:0] x,
    input int          a,
    input int          b,
    input int          c,
    input int          w
  );
    logic [63:0] m;
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    x0 = x & m;
    x1 = (x0 ^ (x0 << a)) & m;
    x2 = x1 ^ (x1 >> b);
    return (x2 ^ (x2 << c)) & m;
  endfunction

endpackage

// File: rtl/xorshift_lane.sv
// One xorshift lane: state register, load/advance, seed derivation.
// Ports: clk, rst_n, i_load, i_adv, i_seed[WIDTH], o_state[WIDTH].
module xorshift_lane
  import xorshift_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               IDX          = 0,
  parameter int               SH_A         = 13,
  parameter int               SH_B         = 17,
  parameter int               SH_C         = 5,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(32'h1234_5678),
  parameter logic [WIDTH-1:0] ZERO_SUB     = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_state
);

  localparam logic [63:0] GOLD =
    (WIDTH == 64) ? GOLDEN64 : {32'h0, GOLDEN32};
  localparam logic [63:0] MUL64 = 64'(IDX) * GOLD;
  localparam logic [WIDTH-1:0] OFS = MUL64[WIDTH-1:0];

  // Per-lane decorrelation; a zero result would lock the lane.
  function automatic logic [WIDTH-1:0] derive(
    input logic [WIDTH-1:0] s
  );
    logic [WIDTH-1:0] d;
    d = s ^ OFS;
    return (d == '0) ? ZERO_SUB : d;
  endfunction

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;

  assign w_next = WIDTH'(xs_step(64'(r_state),
                                 SH_A, SH_B, SH_C, WIDTH));
  assign w_seed = derive(i_seed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= derive(SEED_DEFAULT);
    end else if (i_load) begin
      r_state <= w_seed;
    end else if (i_adv) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/xorshift_multi.sv
// NCH-lane lockstep xorshift source with reseed/warm-up FSM.
// Ports: clk, rst_n, seed, re_seed, rnd, rnd_valid, rnd_ready, busy.
module xorshift_multi
  import xorshift_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               NCH          = 4,
  parameter int               SH_A         = 13,
  parameter int               SH_B         = 17,
  parameter int               SH_C         = 5,
  parameter int               WARMUP       = 8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(32'h1234_5678),
  parameter logic [WIDTH-1:0] ZERO_SUB     = WIDTH'(1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     seed,
  input  logic                 re_seed,
  output logic [NCH*WIDTH-1:0] rnd,
  output logic                 rnd_valid,
  input  logic                 rnd_ready,
  output logic                 busy
);

  localparam int CW =
    (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WARMUP);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam state_t ST_INIT =
    (WARMUP == 0) ? ST_RUN : ST_WARMUP;
  localparam state_t ST_AFTER_SEED =
    (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_seed;
  logic             w_load;
  logic             w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed <= SEED_DEFAULT;
      r_cnt  <= '0;
    end else begin
      if (re_seed) begin
        r_seed <= seed;
      end
      if (r_state == ST_SEED) begin
        r_cnt <= '0;
      end else if (r_state == ST_WARMUP &&
                   r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // re_seed wins over everything, including a pending handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (re_seed) begin
      w_state_nxt = ST_SEED;
    end else begin
      unique case (r_state)
        ST_SEED:   w_state_nxt = ST_AFTER_SEED;
        ST_WARMUP: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN:    w_state_nxt = ST_RUN;
        default:   w_state_nxt = ST_SEED;
      endcase
    end
  end

  always_comb begin
    rnd_valid = (r_state == ST_RUN);
    busy      = !rnd_valid;
    w_load    = (r_state == ST_SEED);
    w_adv     = (r_state == ST_WARMUP) ||
                (rnd_valid && rnd_ready && !re_seed);
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    xorshift_lane #(
      .WIDTH       (WIDTH),
      .IDX         (gi),
      .SH_A        (SH_A),
      .SH_B        (SH_B),
      .SH_C        (SH_C),
      .SEED_DEFAULT(SEED_DEFAULT),
      .ZERO_SUB    (ZERO_SUB)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_adv  (w_adv),
      .i_seed (r_seed),
      .o_state(rnd[gi*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_xorshift_multi.sv
// Bench for xorshift_multi: three configurations against a latency model.
// Directed reseed/back-pressure/reset vectors plus literal anchors.
module tb_xorshift_multi;

  localparam int NC [3] = '{2, 1, 4};
  localparam int WU [3] = '{0, 2, 8};
  localparam logic [31:0] DEF = 32'h1234_5678;

  logic         clk;
  logic         rst_n;
  logic [31:0]  sd  [3];
  logic         rs  [3];
  logic         rdy [3];
  logic         v   [3];
  logic         b   [3];
  logic [63:0]  rnd0;
  logic [31:0]  rnd1;
  logic [127:0] rnd2;

  int total = 0;
  int bad   = 0;
  bit en    = 0;

  logic [31:0] m_lane [3][4];
  int          m_wait [3];

  xorshift_multi #(.WIDTH(32), .NCH(2), .WARMUP(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .seed(sd[0]), .re_seed(rs[0]),
    .rnd(rnd0), .rnd_valid(v[0]), .rnd_ready(rdy[0]),
    .busy(b[0]));

  xorshift_multi #(.WIDTH(32), .NCH(1), .WARMUP(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .seed(sd[1]), .re_seed(rs[1]),
    .rnd(rnd1), .rnd_valid(v[1]), .rnd_ready(rdy[1]),
    .busy(b[1]));

  xorshift_multi #(.WIDTH(32), .NCH(4), .WARMUP(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .seed(sd[2]), .re_seed(rs[2]),
    .rnd(rnd2), .rnd_valid(v[2]), .rnd_ready(rdy[2]),
    .busy(b[2]));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  function automatic logic [31:0] fpow(input logic [31:0] x,
                                       input int n);
    logic [31:0] y;
    y = x;
    for (int j = 0; j < n; j++) y = f32(y);
    return y;
  endfunction

  function automatic logic [31:0] derive(input logic [31:0] s,
                                         input int i);
    logic [31:0] d;
    d = s ^ (32'(i) * 32'h9E37_79B9);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

  function automatic logic [31:0] lane(input int k, input int i);
    logic [31:0] r;
    r = '0;
    if (k == 0) r = rnd0[i*32 +: 32];
    else if (k == 1) r = rnd1;
    else r = rnd2[i*32 +: 32];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // After a reseed the lanes show f^WARMUP(d_i) once 1+WARMUP edges
  // have passed; from then on each accepted value steps f once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_wait[k] <= WU[k];
        for (int i = 0; i < 4; i++)
          m_lane[k][i] <= fpow(derive(DEF, i), WU[k]);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rs[k]) begin
          m_wait[k] <= 1 + WU[k];
          for (int i = 0; i < 4; i++)
            m_lane[k][i] <= fpow(derive(sd[k], i), WU[k]);
        end else if (m_wait[k] > 0) begin
          m_wait[k] <= m_wait[k] - 1;
        end else if (rdy[k]) begin
          for (int i = 0; i < 4; i++)
            m_lane[k][i] <= f32(m_lane[k][i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("valid%0d", k), 64'(v[k]),
            64'(m_wait[k] == 0));
        chk($sformatf("busy%0d", k), 64'(b[k]),
            64'(m_wait[k] != 0));
        if (m_wait[k] == 0) begin
          for (int i = 0; i < NC[k]; i++)
            chk($sformatf("rnd%0d_%0d", k, i),
                64'(lane(k, i)), 64'(m_lane[k][i]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    for (int k = 0; k < 3; k++) begin
      sd[k]  = '0;
      rs[k]  = 0;
      rdy[k] = 1;
    end

    chk("model_f1", 64'(f32(32'd1)), 64'd270369);
    chk("model_f2", 64'(fpow(32'd1, 2)), 64'd67634689);
    chk("model_zs", 64'(derive(32'h9E37_79B9, 1)), 64'd1);

    repeat (2) tick();
    @(negedge clk);
    chk("rst_v0", 64'(v[0]), 64'd1);
    chk("rst_b1", 64'(b[1]), 64'd1);
    chk("rst_l00", 64'(rnd0[31:0]), 64'h1234_5678);
    chk("rst_l01", 64'(rnd0[63:32]), 64'h8C03_2FC1);
    en = 1;
    rst_n = 1;
    repeat (3) tick();

    // Lane 0, seed 1, no warm-up, with back-pressure.
    sd[0] = 32'd1;
    rs[0] = 1;
    tick();
    rs[0] = 0;
    @(negedge clk);
    chk("rs_busy", 64'(v[0]), 64'd0);
    tick();
    @(negedge clk);
    chk("rs_first", 64'(rnd0[31:0]), 64'd1);
    chk("rs_vld", 64'(v[0]), 64'd1);
    tick();
    @(negedge clk);
    chk("rs_second", 64'(rnd0[31:0]), 64'd270369);
    rdy[0] = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      @(negedge clk);
      chk("hold", 64'(rnd0[31:0]), 64'd270369);
    end
    rdy[0] = 1;
    tick();
    @(negedge clk);
    chk("resume", 64'(rnd0[31:0]), 64'd67634689);

    // Lane 1 derives zero and takes the substitute.
    sd[0] = 32'h9E37_79B9;
    rs[0] = 1;
    tick();
    rs[0] = 0;
    tick();
    @(negedge clk);
    chk("zs_l0", 64'(rnd0[31:0]), 64'h9E37_79B9);
    chk("zs_l1", 64'(rnd0[63:32]), 64'd1);
    tick();
    @(negedge clk);
    chk("zs_l1b", 64'(rnd0[63:32]), 64'd270369);

    // Two-cycle warm-up.
    sd[1] = 32'd1;
    rs[1] = 1;
    tick();
    rs[1] = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("wu2_busy", 64'(b[1]), 64'd1);
      tick();
    end
    @(negedge clk);
    chk("wu2_vld", 64'(v[1]), 64'd1);
    chk("wu2_val", 64'(rnd1), 64'd67634689);

    // Reseed aborting an 8-cycle warm-up on its 4th cycle.
    sd[2] = 32'd1;
    rs[2] = 1;
    tick();
    rs[2] = 0;
    repeat (4) tick();
    rs[2] = 1;
    tick();
    rs[2] = 0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      @(negedge clk);
      chk("wu8_vld", 64'(v[2]), 64'(n == 9));
    end
    chk("wu8_val", 64'(rnd2[31:0]), 64'(fpow(32'd1, 8)));
    repeat (3) tick();

    // Reseed coinciding with a handshake.
    sd[2] = 32'hDEAD_BEEF;
    rs[2] = 1;
    tick();
    rs[2] = 0;
    @(negedge clk);
    chk("rsh_vld", 64'(v[2]), 64'd0);
    repeat (12) tick();

    // Asynchronous reset mid-run.
    #2;
    rst_n = 0;
    #1;
    chk("arst_v2", 64'(v[2]), 64'd0);
    chk("arst_l20", 64'(rnd2[31:0]), 64'h1234_5678);
    chk("arst_l21", 64'(rnd2[63:32]), 64'h8C03_2FC1);
    chk("arst_v0", 64'(v[0]), 64'd1);
    @(negedge clk);
    rst_n = 1;
    repeat (14) tick();

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xorshift_multi.md
Name: xorshift_multi

Overview:
- Parametrised successor to the single-lane 32-bit xorshift generator: NCH independent lanes of WIDTH-bit xorshift state, advanced in lockstep.
- Adds a valid/ready output handshake and a reseed FSM with per-lane seed decorrelation, zero-seed protection and a configurable warm-up discard phase.
- Sits as the shared random source feeding stochastic-computing SNG arrays; downstream consumers apply back-pressure through rnd_ready.

Parameters:
- WIDTH, 32, lane state/output width; legal values 32 or 64.
- NCH, 4, number of lanes (1..16).
- SH_A, 13, first left-shift amount (x ^= x << SH_A).
- SH_B, 17, right-shift amount (x ^= x >> SH_B).
- SH_C, 5, second left-shift amount (x ^= x << SH_C).
- WARMUP, 8, number of discarded advances after every seed load (0 allowed).
- SEED_DEFAULT, 32'h1234_5678 (zero-extended to WIDTH), seed applied at reset.
- ZERO_SUB, 1, substitute state for any lane whose derived seed is 0.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- seed, in, WIDTH, reseed value; sampled only when re_seed=1.
- re_seed, in, 1, single-cycle reseed request.
- rnd, out, NCH*WIDTH, lane i on bits [i*WIDTH +: WIDTH].
- rnd_valid, out, 1, rnd holds valid numbers.
- rnd_ready, in, 1, consumer accepts rnd this cycle.
- busy, out, 1, high in SEED or WARMUP state.

Behaviour:
- Step function f(x): x1 = x ^ (x << SH_A); x2 = x1 ^ (x1 >> SH_B); x3 = x2 ^ (x2 << SH_C). All operations are truncated to WIDTH; the shifts are logical.
- Lane seed derivation: d_i = S ^ (i * GOLDEN), truncated to WIDTH. GOLDEN is 32'h9E37_79B9 for WIDTH=32 and 64'h9E37_79B9_7F4A_7C15 for WIDTH=64. If d_i == 0, the lane loads ZERO_SUB. Lane 0 therefore loads S unchanged when S != 0.
- Output convention: rnd = current lane state (pre-update). The state advances to f(state) on the clock edge where rnd_valid & rnd_ready.
- FSM states: SEED, WARMUP, RUN.
- SEED (1 cycle): load d_i into every lane, clear warm-up counter, then go to WARMUP. If WARMUP=0, go directly to RUN.
- WARMUP: every lane advances each cycle regardless of rnd_ready; the counter increments. After WARMUP advances, go to RUN.
- RUN: rnd_valid=1. The state advances only on a handshake. With rnd_ready=0, rnd holds stable indefinitely.
- re_seed=1 in any state: capture seed and enter SEED on the next edge. This aborts WARMUP or RUN. re_seed has priority over a simultaneous handshake; that handshake's state advance is dropped.
- rnd_valid is 0 in SEED and WARMUP. busy = !rnd_valid.
- Reset (async assert, synchronous-release semantics left to the top level): every lane loads the SEED_DEFAULT-derived d_i, counter = 0, FSM = WARMUP (RUN if WARMUP=0). On reset: rnd = derived default seeds, rnd_valid = 0 (1 if WARMUP=0), busy = 1 (0 if WARMUP=0).
- Reset mid-warmup or mid-run restarts the warm-up from the default seeds.
- Warm-up counter is $clog2(WARMUP+1) bits wide and saturates at WARMUP; it does not wrap.
- No lane can reach an all-zero state: the seeds are nonzero and f is a bijection.

Decomposition:
- Package xorshift_pkg holds:
  - GOLDEN32 and GOLDEN64 constants;
  - default shift triples (13/17/5 for 32-bit, 13/7/17 for 64-bit);
  - the state enum {ST_SEED, ST_WARMUP, ST_RUN};
  - a function xs_step(x, a, b, c).
- One sub-module, xorshift_lane: holds the WIDTH-bit state register, load/advance controls, seed derivation and zero substitution. The top generates NCH instances and holds the FSM.

Test Plan:
- NCH=1, WARMUP=0, reseed with seed=1 → rnd_valid=1 two edges after re_seed; with rnd_ready=1 the accepted values are 1, 270369, 67634689.
- Same configuration, rnd_ready=0 for 5 cycles after the first value → rnd stays 270369 with rnd_valid=1; releasing ready resumes at 67634689.
- NCH=2, WARMUP=0, seed=32'h9E37_79B9 → lane1 derives 0 and loads ZERO_SUB. Lane0 yields 32'h9E37_79B9 then f(32'h9E37_79B9); lane1 yields 1 then 270369.
- NCH=1, WARMUP=2, seed=1 → busy=1 for 3 cycles (SEED plus 2 warm-up cycles), with rnd_valid=0 throughout; the first accepted rnd is 67634689.
- WARMUP=8, assert re_seed (seed=1) on warm-up cycle 4 → FSM re-enters SEED, the counter restarts, and valid first rises 9 cycles later with f^8(1).
- RUN with rnd_ready=1 and re_seed=1 on the same edge → no advance from the old state; the lanes load the new seed; rst_n pulsed low mid-run → rnd_valid=0 immediately and the lanes show the SEED_DEFAULT-derived seeds.
